// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch prefetch stage.
//   if_state_e        : fetch control state (boot / fetch / flush)
//   RESET_PC_DEFAULT  : default reset vector (word address)
//   DEPTH_DEFAULT     : default prefetch depth and outstanding-request cap
//   CNT_W_DEFAULT     : counter width able to hold 0..DEPTH_DEFAULT
package if_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } if_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0400;
  localparam int unsigned DEPTH_DEFAULT    = 4;
  localparam int unsigned CNT_W_DEFAULT    = $clog2(DEPTH_DEFAULT + 1);

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO holding {pc, instruction} pairs between fetch and ID.
//   clk, rst : clock, asynchronous active-high reset
//   push,din : write request and data (caller guarantees not full)
//   pop      : read request (caller guarantees not empty)
//   clear    : drop all entries; has priority over push/pop
//   dout     : head entry, read straight from the storage flops
//   count    : number of valid entries (0..DEPTH)
module if_fifo
  import if_pkg::*;
#(
  parameter int unsigned WIDTH = 63,
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: PC generator, in-order variable-latency imem
// request/response interface and a DEPTH-entry prefetch FIFO toward ID.
//   i_clock, i_reset               : clock, asynchronous active-high reset
//   i_select, i_branch_address     : redirect strobe and target from EX
//   o_imem_valid, o_imem_addr      : memory request (held while !i_imem_ready)
//   i_imem_ready                   : memory accepts request
//   i_imem_rvalid, i_imem_rdata    : in-order memory response
//   o_valid, o_address, o_instruccion, i_ready : ID handshake
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 31,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = DEPTH_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_select,
  input  logic [ADDR_W-1:0] i_branch_address,
  output logic              o_imem_valid,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ready,
  input  logic              i_imem_rvalid,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_instruccion,
  input  logic              i_ready
);

  localparam int unsigned      CNT_W     = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_CNT = (CNT_W + 1)'(DEPTH);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;

  logic                     sel;
  logic                     rvalid;
  logic                     credit;
  logic                     issue;
  logic                     push;
  logic                     pop;
  logic [CNT_W-1:0]         fifo_count;
  logic [ADDR_W+DATA_W-1:0] fifo_head;

  // Redirects are ignored during boot; responses with nothing outstanding are
  // leftovers from before a reset and are ignored as well.
  assign sel    = i_select && (state_q != S_BOOT);
  assign rvalid = i_imem_rvalid && (outstanding_q != '0);

  // Credit counts discarded-but-outstanding responses too, so every kept
  // response always finds a free FIFO slot.
  assign credit = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < DEPTH_CNT;
  assign issue  = o_imem_valid && i_imem_ready;
  assign push   = rvalid && (discard_q == '0) && !sel;
  assign pop    = o_valid && i_ready;

  assign o_valid     = (fifo_count != '0) && !i_select;
  assign o_imem_addr = pc_q;

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Datapath next values
  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (sel) begin
      pc_d = i_branch_address;
    end else if (issue) begin
      pc_d = pc_q + ADDR_W'(1);
    end

    case ({issue, rvalid})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // Everything still in flight after this cycle belongs to the old path.
    if (sel) begin
      discard_d = outstanding_q - CNT_W'(rvalid);
    end else if (rvalid && (discard_q != '0)) begin
      discard_d = discard_q - CNT_W'(1);
    end

    if (sel) begin
      resp_pc_d = i_branch_address;
    end else if (push) begin
      resp_pc_d = resp_pc_q + ADDR_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH, S_FLUSH: begin
        if (sel) begin
          state_d = (discard_d != '0) ? S_FLUSH : S_FETCH;
        end else if ((state_q == S_FLUSH) && (discard_d == '0)) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Output logic
  always_comb begin
    o_imem_valid = (state_q != S_BOOT) && !i_select && credit;
  end

  if_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (i_clock),
    .rst   (i_reset),
    .push  (push),
    .din   ({resp_pc_q, i_imem_rdata}),
    .pop   (pop),
    .clear (sel),
    .dout  (fifo_head),
    .count (fifo_count)
  );

  assign o_address     = fifo_head[ADDR_W+DATA_W-1:DATA_W];
  assign o_instruccion = fifo_head[DATA_W-1:0];

endmodule
